// File: rtl/dbg_display_ctrl.sv
// Debug front-end: debounced single-step / auto-run step pulse and a scanned 7-segment channel view.
// Optional build macro: DISP_BLANK_LEADING_EN blanks leading zero digits.
module dbg_display_ctrl #(
  parameter int unsigned NUM_CH          = 5,
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned SEL_W           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned RUN_DIV         = 25000000
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         button,
  input  logic                         run_mode,
  input  logic [SEL_W-1:0]             sw,
  input  logic [NUM_CH*DIGITS*4-1:0]   ch_data,
  output logic                         step,
  output logic [6:0]                   seg,
  output logic [DIGITS-1:0]            AN
);

  localparam int unsigned ChW   = DIGITS * 4;
  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned RunW  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic             sync1_q, sync2_q;
  logic             db_q, db_d, db_prev_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic             run_wrap;
  logic             step_q, step_d;
  logic [ChW-1:0]   disp_q, disp_d;
  logic             valid_q, valid_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic             scan_wrap;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]       nibble;
  logic             blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Debounce: accept the synchronised level only after it differs for DEBOUNCE_CYCLES edges.
  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    run_wrap  = run_mode && (run_cnt_q == RunW'(RUN_DIV - 1));
    run_cnt_d = '0;
    if (run_mode && !run_wrap) run_cnt_d = run_cnt_q + 1'b1;
    step_d = run_mode ? run_wrap : (db_q & ~db_prev_q);
  end

  always_comb begin
    disp_d  = disp_q;
    valid_d = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (sw == SEL_W'(k)) begin
        disp_d  = ch_data[k*ChW +: ChW];
        valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // Digit outputs are derived from the current index so AN and seg move together.
  always_comb begin
    nibble = '0;
    an_d   = '1;
    blank  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nibble   = disp_q[4*i +: 4];
        an_d[i]  = 1'b0;
      end
    end
`ifdef DISP_BLANK_LEADING_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        upper_zero = upper_zero & (disp_q[4*i +: 4] == 4'h0);
        if (idx_q == IdxW'(i)) blank = upper_zero;
      end
    end
`endif
    if (!valid_q)   seg_d = 7'h3F;
    else if (blank) seg_d = 7'h7F;
    else            seg_d = hex7(nibble);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      run_cnt_q  <= '0;
      step_q     <= 1'b0;
      disp_q     <= '0;
      valid_q    <= 1'b1;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      db_cnt_q   <= db_cnt_d;
      run_cnt_q  <= run_cnt_d;
      step_q     <= step_d;
      disp_q     <= disp_d;
      valid_q    <= valid_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign step = step_q;
  assign seg  = seg_q;
  assign AN   = an_q;

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Bench for dbg_display_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_dbg_display_ctrl;

  localparam int NUM_CH = 5;
  localparam int DIGITS = 4;
  localparam int SEL_W  = 3;
  localparam int DB     = 4;
  localparam int SD     = 2;
  localparam int RD     = 8;

  localparam logic [6:0] HexLut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                       clk = 1'b0;
  logic                       Reset, button, run_mode;
  logic [SEL_W-1:0]           sw;
  logic [NUM_CH*DIGITS*4-1:0] ch_data;
  logic                       step;
  logic [6:0]                 seg;
  logic [DIGITS-1:0]          AN;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ticks  = 0;
  int pulses   = 0;
  int last_pulse = -1;
  bit chk_spacing = 1'b0;

  // Behavioural model state
  logic m_p1, m_p2, m_db, m_rose, m_valid;
  int   m_run, m_rm, m_tick;
  logic [15:0] m_disp;
  logic        e_step;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;

  always #5 clk = ~clk;

  dbg_display_ctrl #(
    .NUM_CH(NUM_CH), .DIGITS(DIGITS), .SEL_W(SEL_W),
    .DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD), .RUN_DIV(RD)
  ) dut (
    .clk(clk), .Reset(Reset), .button(button), .run_mode(run_mode),
    .sw(sw), .ch_data(ch_data), .step(step), .seg(seg), .AN(AN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (tick %0d)", tag, obs, exp, n_ticks);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [15:0] d, input logic v, input int i);
    if (!v) return 7'h3F;
`ifdef DISP_BLANK_LEADING_EN
    if (i > 0 && (d >> (4 * i)) == 16'h0) return 7'h7F;
`endif
    return HexLut[d[4*i +: 4]];
  endfunction

  task automatic model_edge();
    logic s;
    int   idx;
    if (Reset) begin
      m_p1 = 0; m_p2 = 0; m_db = 0; m_rose = 0; m_run = 0; m_rm = 0; m_tick = 0;
      m_disp = '0; m_valid = 1;
      e_step = 0; e_seg = 7'h7F; e_an = 4'hF;
      return;
    end
    idx   = (m_tick / SD) % DIGITS;
    e_an  = 4'(~(4'b0001 << idx));
    e_seg = glyph(m_disp, m_valid, idx);
    if (run_mode) begin
      m_rm++;
      e_step = ((m_rm % RD) == 0);
    end else begin
      m_rm   = 0;
      e_step = m_rose;
    end
    s = m_p2; m_p2 = m_p1; m_p1 = button;
    m_rose = 0;
    if (s != m_db) begin
      m_run++;
      if (m_run == DB) begin m_db = s; m_run = 0; m_rose = s; end
    end else m_run = 0;
    if (int'(sw) < NUM_CH) begin
      m_disp  = ch_data[int'(sw)*16 +: 16];
      m_valid = 1;
    end else m_valid = 0;
    m_tick++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    n_ticks++;
    chk("step", 32'(step), 32'(e_step));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("AN", 32'(AN), 32'(e_an));
    if (step) begin
      if (chk_spacing && last_pulse >= 0) chk("run_spacing", n_ticks - last_pulse, RD);
      pulses++;
      last_pulse = n_ticks;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Runs 8 ticks checking each digit's glyph, then checks every digit was visited.
  task automatic check_scan(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3);
    logic [3:0] seen;
    logic [6:0] exp;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (AN)
        4'hE: begin exp = g0; seen[0] = 1'b1; end
        4'hD: begin exp = g1; seen[1] = 1'b1; end
        4'hB: begin exp = g2; seen[2] = 1'b1; end
        4'h7: begin exp = g3; seen[3] = 1'b1; end
        default: exp = 7'hxx;
      endcase
      chk(tag, 32'(seg), 32'(exp));
    end
    chk({tag, "_digits_seen"}, 32'(seen), 32'hF);
  endtask

  initial begin
    int first_k;
    logic [6:0] blank_g;
    Reset = 1; button = 0; run_mode = 0; sw = '0; ch_data = '0;

    // Reset held 3 cycles
    ticks(3);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_AN", 32'(AN), 32'hF);
    chk("reset_step", 32'(step), 32'h0);
    Reset = 0;
    tick();
    chk("first_scan_AN", 32'(AN), 32'hE);
    chk("first_scan_seg", 32'(seg), 32'h40);
    ticks(4);

    // Short glitch is ignored
    pulses = 0;
    button = 1; ticks(2);
    button = 0; ticks(10);
    chk("glitch_pulses", pulses, 0);

    // Held press gives one pulse on the 7th edge after the rise
    pulses = 0; first_k = -1;
    button = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (step && first_k < 0) first_k = k;
    end
    chk("press_latency", first_k, 7);
    chk("press_pulses", pulses, 1);
    pulses = 0;
    button = 0; ticks(10);
    chk("release_pulses", pulses, 0);

    // Auto-run with a button press inside the window
    pulses = 0; last_pulse = -1; chk_spacing = 1;
    run_mode = 1;
    ticks(10);
    button = 1; ticks(8);
    button = 0; ticks(22);
    chk("run_pulses", pulses, 5);
    chk_spacing = 0;
    pulses = 0;
    run_mode = 0; ticks(20);
    chk("run_stop_pulses", pulses, 0);

    // Channel 2 scan
    ch_data[2*16 +: 16] = 16'h1A3F;
    sw = 3'd2; ticks(2);
    check_scan("ch2_scan", 7'h0E, 7'h30, 7'h08, 7'h79);

    // Out-of-range select shows dashes, then channel 0
    sw = 3'd6; ticks(2);
    check_scan("dash_scan", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    ch_data[0 +: 16] = 16'h00C4;
    sw = 3'd0; ticks(2);
`ifdef DISP_BLANK_LEADING_EN
    blank_g = 7'h7F;
`else
    blank_g = 7'h40;
`endif
    check_scan("ch0_scan", 7'h19, 7'h46, blank_g, blank_g);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0)  button = ~button;
      if ($urandom_range(29) == 0) run_mode = ~run_mode;
      if ($urandom_range(9) == 0)  sw = SEL_W'($urandom_range(7));
      if ($urandom_range(19) == 0) ch_data = {$urandom(), $urandom(), $urandom()};
      Reset = ($urandom_range(79) == 0);
      tick();
    end
    Reset = 1; button = 0; run_mode = 0; sw = '0; tick();
    Reset = 0; ticks(3);

    // Reset mid-debounce and mid-scan
    pulses = 0;
    button = 1; ticks(5);
    Reset = 1; button = 0; tick();
    chk("midreset_seg", 32'(seg), 32'h7F);
    chk("midreset_AN", 32'(AN), 32'hF);
    chk("midreset_step", 32'(step), 32'h0);
    Reset = 0; ticks(20);
    chk("midreset_pulses", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_display_ctrl.md
Name: dbg_display_ctrl

Overview:
Parametrised debug front-end for the board top level. It debounces the step button into a one-cycle CPU step pulse, and offers an auto-run mode with a programmable step rate. Switches select one of NUM_CH packed debug channels, which is scanned onto an active-low multiplexed seven-segment display of DIGITS hex digits.

Parameters:
NUM_CH, 5, number of debug channels on ch_data
DIGITS, 4, seven-segment digits; each channel is DIGITS*4 bits
SEL_W, 3, width of sw; must satisfy 2**SEL_W >= NUM_CH
DEBOUNCE_CYCLES, 100000, consecutive stable clk cycles needed to accept a button level
SCAN_DIV, 50000, clk cycles each digit stays enabled
RUN_DIV, 25000000, clk cycles between step pulses in run mode

Ports:
clk  in  1  system clock
Reset  in  1  synchronous active-high reset
button  in  1  raw asynchronous step push-button
run_mode  in  1  1 = auto-step every RUN_DIV cycles; 0 = button single-step
sw  in  SEL_W  channel select
ch_data  in  NUM_CH*DIGITS*4  packed channels; channel k = bits [(k+1)*DIGITS*4-1 : k*DIGITS*4]
step  out  1  one-clk-wide CPU step/clock-enable pulse
seg  out  7  segments {g,f,e,d,c,b,a}, active low
AN  out  DIGITS  digit enables, active low, one-hot-cold

Behaviour:
- One clock domain, clk. Reset is sampled only on the rising edge of clk.
- Reset values: step=0, seg=7'h7F, AN all ones, all counters 0, sync and debounced level 0, display register 0.
- A reset asserted mid-operation takes effect at the next edge and discards any pending debounce, run count or scan position.
- Button sync: 2-FF synchroniser.
- Debounce: counter compares the synchronised level with the debounced level.
  - Mismatch: increment; when the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value and the counter clears.
  - Match: counter clears.
  - Any bounce shorter than DEBOUNCE_CYCLES is ignored.
- Step in button mode (run_mode=0): step=1 for exactly one cycle, in the cycle after the debounced level rises 0->1. The falling edge produces nothing. Holding the button produces a single pulse.
- Step in run mode (run_mode=1): run counter counts 0..RUN_DIV-1 and wraps. step=1 in the cycle the counter wraps. The button is ignored, but the debouncer keeps tracking it.
- Mode changes: the run counter clears while run_mode=0. Switching 0->1 gives the first pulse RUN_DIV cycles later. Switching 1->0 stops auto pulses immediately.
- A debounced rising edge that coincides with run mode produces no pulse.
- Channel select: display register <= channel sw when sw < NUM_CH; updated every clk, latency 1 cycle.
- sw >= NUM_CH: display register is unchanged. Each digit shows the dash glyph (only g lit: seg=7'h3F) until a valid sw is presented.
- Scan: scan counter counts 0..SCAN_DIV-1. On wrap, digit index increments modulo DIGITS (DIGITS-1 wraps to 0).
- Digit 0 is the rightmost digit and shows display[3:0]. Digit i shows display[4i+3:4i].
- AN bit i = 0 only while digit index = i.
- seg is registered: it reflects the current digit index and display register one cycle after either changes.
- Hex decode, active low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex values of seg).
- AN and seg update on the same edge, so no ghosting cycle.

Optional Feature:
DISP_BLANK_LEADING_EN
- Defined: leading-zero blanking. Digit i shows seg=7'h7F if every nibble from i up to DIGITS-1 is zero. Digit 0 is never blanked, so a value of 0 shows a single "0". Dash glyph is unaffected.
- Undefined: all digits always decoded, including leading zeros.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, SCAN_DIV=2, RUN_DIV=8, NUM_CH=5, DIGITS=4.
- Reset held 3 cycles, then released -> seg=7F, AN=F, step=0 during reset. First scan gives AN=E, seg=40 (display 0).
- Button glitches high 2 cycles, then low -> no step pulse. Button held high 10 cycles -> exactly one step pulse, 2 sync + 4 debounce cycles (+1) after the rise; release -> none.
- run_mode=1 for 40 cycles -> step pulses spaced exactly 8 cycles apart, 5 total. A button press during this window adds none. run_mode 1->0 -> pulses stop.
- ch_data channel 2 = 16'h1A3F, sw=2 -> over 8 clks AN sequence E,D,B,7 with seg 0E,30,08,79.
- sw=6 (out of range) -> every digit seg=3F; then sw=0 with channel 0 = 16'h00C4 -> digits 19,46,40,40 (with the macro: 19,46,7F,7F).
- Reset asserted mid-debounce and mid-scan -> next cycle all outputs are at reset values, and no step pulse is ever emitted for that press.
